// File: rtl/map_writer.sv
`default_nettype none
// ============================================================================
// Module   : map_writer
// Brief    : Loads a full RGB444 map from a byte stream into map RAM.
//            Each pixel is two bytes: {xxxx,R} followed by {G,B}.
// Revision : 1.0 - initial release
// ============================================================================
module map_writer #(
   parameter int MAP_W = 512,
   parameter int MAP_H = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        wr_en,
   output logic [15:0] wr_adr,
   output logic [11:0] wr_data,
   output logic        busy,
   output logic        done
);

   localparam logic [8:0] c_COL_LAST = 9'(MAP_W - 1);
   localparam logic [6:0] c_ROW_LAST = 7'(MAP_H - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HI    = 3'd1,
      LO    = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t     r_state;
   logic [6:0] r_row;
   logic [8:0] r_col;
   logic [3:0] r_red;

   // All outputs are set alongside the state they belong to, so each one is
   // a flop reflecting the state the FSM is entering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_row    <= 7'd0;
         r_col    <= 9'd0;
         r_red    <= 4'd0;
         rx_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_adr   <= 16'd0;
         wr_data  <= 12'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  r_state  <= HI;
                  r_row    <= 7'd0;
                  r_col    <= 9'd0;
                  rx_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            HI: begin
               if (abort) begin
                  r_state  <= IDLE;
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
               end else if (rx_valid && rx_ready) begin
                  r_red   <= rx_data[3:0];
                  r_state <= LO;
               end
            end
            LO: begin
               if (abort) begin
                  r_state  <= IDLE;
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
               end else if (rx_valid && rx_ready) begin
                  // wr_data doubles as the G/B latch so it holds between writes
                  r_state  <= WRITE;
                  rx_ready <= 1'b0;
                  wr_en    <= 1'b1;
                  wr_adr   <= {r_row, r_col};
                  wr_data  <= {r_red, rx_data};
               end
            end
            WRITE: begin
               if (abort) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end else if (r_col != c_COL_LAST) begin
                  r_col    <= r_col + 9'd1;
                  r_state  <= HI;
                  rx_ready <= 1'b1;
               end else begin
                  r_col <= 9'd0;
                  if (r_row != c_ROW_LAST) begin
                     r_row    <= r_row + 7'd1;
                     r_state  <= HI;
                     rx_ready <= 1'b1;
                  end else begin
                     r_state <= FIN;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            FIN: begin
               r_state <= IDLE;
            end
            default: begin
               r_state  <= IDLE;
               rx_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_map_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_writer
// Brief    : Directed self-checking bench for map_writer on a 4x2 map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_writer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr_en;
   logic [15:0] wr_adr;
   logic [11:0] wr_data;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   map_writer #(.MAP_W(4), .MAP_H(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .wr_en    (wr_en),
      .wr_adr   (wr_adr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int n;
      if (rnd) begin
         repeat ($urandom_range(0, 2)) begin
            rx_valid = 1'b0;
            @(negedge clk);
         end
      end
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("handshake_timeout", 32'(n < 20), 32'd1);
      @(negedge clk);
   endtask

   task automatic pixel(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [15:0] adr, input logic [11:0] dat, input bit rnd);
      send_byte(b0, rnd);
      chk("lo_wr_en", 32'(wr_en), 32'd0);
      chk("lo_rx_ready", 32'(rx_ready), 32'd1);
      send_byte(b1, rnd);
      chk("wr_en", 32'(wr_en), 32'd1);
      chk("wr_adr", 32'(wr_adr), 32'(adr));
      chk("wr_data", 32'(wr_data), 32'(dat));
      chk("write_rx_ready", 32'(rx_ready), 32'd0);
      chk("write_busy", 32'(busy), 32'd1);
      chk("write_done", 32'(done), 32'd0);
   endtask

   task automatic start_load();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_rx_ready", 32'(rx_ready), 32'd1);
   endtask

   task automatic full_load(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [11:0] dat, input bit rnd);
      start_load();
      for (int k = 0; k < 8; k++)
         pixel(b0, b1, 16'((k / 4) * 512 + (k % 4)), dat, rnd);
      @(negedge clk);
      chk("fin_done", 32'(done), 32'd1);
      chk("fin_busy", 32'(busy), 32'd0);
      chk("fin_wr_en", 32'(wr_en), 32'd0);
      @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_rx_ready", 32'(rx_ready), 32'd0);
      chk("hold_adr", 32'(wr_adr), 32'h0203);
      chk("hold_data", 32'(wr_data), 32'(dat));
      rx_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      #1;
      chk("rst_rx_ready", 32'(rx_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_adr", 32'(wr_adr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full load with continuous valid, then with random valid gaps
      full_load(8'h0A, 8'hBC, 12'hABC, 1'b0);
      full_load(8'h31, 8'h7D, 12'h17D, 1'b1);

      // Bytes offered in IDLE are not consumed
      rx_data  = 8'h01;
      rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_rx_ready", 32'(rx_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      start_load();
      pixel(8'h0A, 8'hBC, 16'h0000, 12'hABC, 1'b0);
      // start during busy must not restart the load
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      pixel(8'h02, 8'h34, 16'h0001, 12'h234, 1'b0);
      pixel(8'h05, 8'h67, 16'h0002, 12'h567, 1'b0);

      // Abort in LO with a simultaneous handshake
      send_byte(8'h0A, 1'b0);
      rx_data = 8'hBC;
      abort   = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rx_ready", 32'(rx_ready), 32'd0);
      chk("abort_wr_en", 32'(wr_en), 32'd0);
      chk("abort_hold_adr", 32'(wr_adr), 32'h0002);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_wr", 32'(wr_en), 32'd0);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      rx_valid = 1'b0;

      // abort wins over start in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_busy", 32'(busy), 32'd0);
      chk("abort_start_ready", 32'(rx_ready), 32'd0);

      // New load restarts at address 0; abort during WRITE
      start_load();
      pixel(8'h0A, 8'hBC, 16'h0000, 12'hABC, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_wr_busy", 32'(busy), 32'd0);
      chk("abort_wr_done", 32'(done), 32'd0);
      chk("abort_wr_ready", 32'(rx_ready), 32'd0);
      rx_valid = 1'b0;

      // Asynchronous reset while in LO
      start_load();
      pixel(8'h0A, 8'hBC, 16'h0000, 12'hABC, 1'b0);
      pixel(8'h0A, 8'hBC, 16'h0001, 12'hABC, 1'b0);
      send_byte(8'h0A, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rx_ready", 32'(rx_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_wr_adr", 32'(wr_adr), 32'd0);
      chk("arst_wr_data", 32'(wr_data), 32'd0);
      chk("arst_wr_en", 32'(wr_en), 32'd0);
      rx_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // High nibble of the first byte is ignored
      start_load();
      pixel(8'hF5, 8'h6E, 16'h0000, 12'h56E, 1'b0);
      @(negedge clk);
      chk("single_cycle_wr_en", 32'(wr_en), 32'd0);
      chk("next_pixel_ready", 32'(rx_ready), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      rx_valid = 1'b0;
      chk("final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/map_writer.md
MAP_WRITER -- requirements
Module: map_writer

Interface
REQ-001 Parameter MAP_W, default 512, map width in pixels (columns); legal 2..512.
REQ-002 Parameter MAP_H, default 128, map height in pixels (rows); legal 1..128.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a full map load.
REQ-006 abort  input  1  cancels a load in progress.
REQ-007 rx_data  input  8  incoming byte stream.
REQ-008 rx_valid  input  1  rx_data valid.
REQ-009 rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high on a clk edge.
REQ-010 wr_en  output  1  map RAM write strobe, one cycle per pixel.
REQ-011 wr_adr  output  16  map RAM address: [15:9] row, [8:0] column (same layout the map reader uses).
REQ-012 wr_data  output  12  pixel RGB: [11:8] R, [7:4] G, [3:0] B.
REQ-013 busy  output  1  high while a load is in progress.
REQ-014 done  output  1  one-cycle pulse when the last pixel has been written.

Function
REQ-015 FSM states SHALL be IDLE, HI, LO, WRITE, FIN.
REQ-016 IDLE: rx_ready=0, busy=0; start=1 -> HI, row=0, col=0; bytes presented in IDLE are not consumed.
REQ-017 HI: rx_ready=1; on accept, latch rx_data[3:0] as R (rx_data[7:4] ignored) -> LO.
REQ-018 LO: rx_ready=1; on accept, latch rx_data[7:4] as G, rx_data[3:0] as B -> WRITE.
REQ-019 WRITE: rx_ready=0; wr_en=1 for exactly this one cycle with wr_adr={row[6:0],col[8:0]} and wr_data={R,G,B}.
REQ-020 Latency: wr_en SHALL be high on the cycle immediately after the LO-byte handshake.
REQ-021 After WRITE: if col<MAP_W-1 then col+1 -> HI; else col=0 and, if row<MAP_H-1, row+1 -> HI; else -> FIN.
REQ-022 FIN: done=1 for one cycle, busy=0 in that cycle -> IDLE.
REQ-023 busy SHALL be 1 in HI, LO, WRITE; 0 in IDLE and FIN.
REQ-024 start while busy SHALL be ignored; load continues unchanged.
REQ-025 abort in HI, LO or WRITE SHALL force IDLE on next edge, suppress any pending wr_en, never produce done; abort has priority over a simultaneous handshake.
REQ-026 abort and start in same IDLE cycle: abort wins, stay IDLE.
REQ-027 rx_valid gaps in HI/LO SHALL simply stall; no timeout.
REQ-028 wr_en, wr_adr, wr_data, rx_ready, busy, done SHALL be registered outputs (no combinational path from inputs).
REQ-029 wr_adr/wr_data hold last written values when wr_en=0; bits of wr_adr beyond row/col range stay 0.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) force IDLE, rx_ready=0, wr_en=0, wr_adr=0, wr_data=0, busy=0, done=0, row=col=0, R/G/B latches=0.
REQ-031 Reset mid-load SHALL discard partial pixel and position; next start begins at address 0.
REQ-032 Deassertion of rst_n is assumed synchronised externally; first active state is IDLE.

Verification
REQ-033 MAP_W=4, MAP_H=2, start then bytes 0x0A,0xBC repeated 8 pixels with continuous rx_valid -> 8 wr_en pulses, first wr_adr=0x0000 data=0xABC, 4th wr_adr=0x0003, 5th wr_adr=0x0200, 8th 0x0203; done pulse one cycle after 8th write; busy falls with done.
REQ-034 Byte 0xF5 then 0x6E -> wr_data=0x56E (high nibble of first byte ignored); wr_en exactly one cycle after 0x6E handshake.
REQ-035 rx_valid toggled randomly (50%) during load -> same write sequence and addresses as REQ-033, rx_ready low during every WRITE cycle.
REQ-036 abort after 3 pixels with first byte of pixel 4 accepted -> no further wr_en, no done, busy=0 next cycle; new start rewrites from wr_adr=0x0000.
REQ-037 rst_n pulled low asynchronously mid-cycle during LO -> outputs zero before next clk edge; start after release writes pixel 0 at 0x0000.
REQ-038 start asserted during busy and rx_valid in IDLE -> no restart, no bytes consumed in IDLE (rx_ready=0).
